// File: rtl/qupls4_agen_seq.sv
// qupls4_agen_seq
// Sequences one load/store address-generator result through the TLB and the
// data cache. An access that spills past a cache line has two phases: line 1,
// then line 2, whose address the generator computes when `next` is driven.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   agen_v/agen_adr      generator result (valid is sticky until agen_clr)
//   acc_sz, is_store     log2 access size (0..4 legal) and direction
//   flush                abort the current sequence
//   agen_next, agen_clr  generator controls: compute next line / clear valid
//   tlb_*                translation request/response
//   dc_*                 data-cache request (line-aligned address + lane select)
//   done, fault          one-cycle completion / abort pulses
//   busy                 sequencer is not idle
module qupls4_agen_seq #(
  parameter int ABITS = 64,
  parameter int LINEB = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     agen_v,
  input  logic [ABITS-1:0]         agen_adr,
  input  logic [2:0]               acc_sz,
  input  logic                     is_store,
  input  logic                     flush,
  output logic                     agen_next,
  output logic                     agen_clr,
  output logic                     tlb_req,
  output logic [ABITS-1:0]         tlb_vadr,
  input  logic                     tlb_ack,
  input  logic [ABITS-1:0]         tlb_padr,
  input  logic                     tlb_fault,
  output logic                     dc_req,
  output logic                     dc_we,
  output logic [ABITS-1:0]         dc_padr,
  output logic [(1<<LINEB)-1:0]    dc_sel,
  input  logic                     dc_ack,
  output logic                     done,
  output logic                     fault,
  output logic                     busy
);

  localparam int LBYTES = 1 << LINEB;
  localparam logic [ABITS-1:0] LINE_MASK = {{(ABITS-LINEB){1'b1}}, {LINEB{1'b0}}};

  typedef enum logic [2:0] {IDLE, XLAT1, REQ1, NXWAIT, XLAT2, REQ2, FIN} state_t;

  state_t              state;
  logic                nx_cnt;
  logic [ABITS-1:0]    vadr_r;
  logic [ABITS-1:0]    padr_r;
  logic [LBYTES-1:0]   sel1_r;
  logic [LBYTES-1:0]   sel2_r;
  logic                cross_r;
  logic                store_r;

  logic                size_bad;
  logic [4:0]          nbytes;
  logic [15:0]         lane_mask;
  logic [2*LBYTES-1:0] span;
  logic                start;

  // Byte lanes touched by the access, laid out over two consecutive lines.
  // The upper half is the spill into line 2; it is non-zero exactly when
  // offset + size - 1 carries past the line boundary.
  always_comb begin
    size_bad  = acc_sz > 3'd4;
    nbytes    = 5'd1 << acc_sz;
    lane_mask = 16'((17'd1 << nbytes) - 17'd1);
    span      = {{(2*LBYTES-16){1'b0}}, lane_mask} << agen_adr[LINEB-1:0];
    // agen_clr high means the generator has not yet dropped valid for the
    // sequence just retired, so agen_v is stale this cycle.
    start     = (state == IDLE) && agen_v && !agen_clr && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      nx_cnt   <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      agen_clr <= 1'b0;
    end else begin
      done     <= 1'b0;
      fault    <= 1'b0;
      agen_clr <= 1'b0;
      if (flush) begin
        state    <= IDLE;
        nx_cnt   <= 1'b0;
        agen_clr <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (size_bad) begin
              fault    <= 1'b1;
              agen_clr <= 1'b1;
            end else begin
              state <= XLAT1;
            end
          end
          XLAT1, XLAT2: if (tlb_ack) begin
            if (tlb_fault) begin
              fault    <= 1'b1;
              agen_clr <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= (state == XLAT1) ? REQ1 : REQ2;
            end
          end
          REQ1: if (dc_ack) begin
            if (cross_r) begin
              state <= NXWAIT;
            end else begin
              state    <= FIN;
              done     <= 1'b1;
              agen_clr <= 1'b1;
            end
          end
          // Two cycles: the generator registers the next-line address one
          // cycle after it sees `next`.
          NXWAIT: begin
            nx_cnt <= ~nx_cnt;
            if (nx_cnt) state <= XLAT2;
          end
          REQ2: if (dc_ack) begin
            state    <= FIN;
            done     <= 1'b1;
            agen_clr <= 1'b1;
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: datapath registers carry no reset; every output that exposes them
  // is gated by state, so their contents are irrelevant until loaded.
  always_ff @(posedge clk) begin
    if (start) begin
      vadr_r  <= agen_adr;
      store_r <= is_store;
      sel1_r  <= span[LBYTES-1:0];
      sel2_r  <= span[2*LBYTES-1:LBYTES];
      cross_r <= |span[2*LBYTES-1:LBYTES];
    end else if ((state == NXWAIT) && nx_cnt && !flush) begin
      vadr_r <= agen_adr;
    end
    if (tlb_ack && ((state == XLAT1) || (state == XLAT2)))
      padr_r <= tlb_padr & LINE_MASK;
  end

  // NOTE: requests are decoded from state and gated by flush combinationally
  // so they drop in the flush cycle itself rather than one cycle later.
  always_comb begin
    tlb_req   = ((state == XLAT1) || (state == XLAT2)) && !flush;
    dc_req    = ((state == REQ1) || (state == REQ2)) && !flush;
    agen_next = (state == NXWAIT) && !flush;
    tlb_vadr  = tlb_req ? vadr_r : '0;
    dc_padr   = dc_req ? padr_r : '0;
    dc_sel    = '0;
    if (dc_req) dc_sel = (state == REQ1) ? sel1_r : sel2_r;
    dc_we     = dc_req && store_r;
    busy      = state != IDLE;
  end

endmodule

// File: tb/tb_qupls4_agen_seq.sv
// Self-checking bench for qupls4_agen_seq. Plays the address generator, TLB
// and data cache; expected lanes, addresses, pulse counts and latency come
// from a byte-level model of the access.
module tb_qupls4_agen_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        agen_v;
  logic [63:0] agen_adr;
  logic [2:0]  acc_sz;
  logic        is_store;
  logic        flush;
  logic        agen_next;
  logic        agen_clr;
  logic        tlb_req;
  logic [63:0] tlb_vadr;
  logic        tlb_ack;
  logic [63:0] tlb_padr;
  logic        tlb_fault;
  logic        dc_req;
  logic        dc_we;
  logic [63:0] dc_padr;
  logic [63:0] dc_sel;
  logic        dc_ack;
  logic        done;
  logic        fault;
  logic        busy;

  always #5 clk = ~clk;

  qupls4_agen_seq dut (
    .clk(clk), .rst(rst), .agen_v(agen_v), .agen_adr(agen_adr),
    .acc_sz(acc_sz), .is_store(is_store), .flush(flush),
    .agen_next(agen_next), .agen_clr(agen_clr),
    .tlb_req(tlb_req), .tlb_vadr(tlb_vadr), .tlb_ack(tlb_ack),
    .tlb_padr(tlb_padr), .tlb_fault(tlb_fault),
    .dc_req(dc_req), .dc_we(dc_we), .dc_padr(dc_padr), .dc_sel(dc_sel),
    .dc_ack(dc_ack), .done(done), .fault(fault), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // model of the current access
  logic [63:0] e_vadr [2];
  logic [63:0] e_padr [2];
  logic [63:0] e_sel  [2];
  logic        e_st;
  logic        e_bad;
  int          e_lines;
  logic [63:0] off;
  int tlb_lat, dc_lat, fline;
  bit force_dc;

  // observed activity
  int tlb_age, dc_age, n_tacc, n_dacc, n_dreq;
  int n_done, n_fault, n_clr, n_next, n_pair, done_at, cyc_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: respond and observe at the falling edge, then apply the
  // generator's registered reaction to agen_clr/agen_next after the rising edge.
  task automatic cyc();
    logic p_clr, p_next;
    @(negedge clk);
    tlb_ack = 1'b0; tlb_fault = 1'b0; tlb_padr = '0; dc_ack = 1'b0;
    if (tlb_req && tlb_age == tlb_lat) begin
      tlb_ack   = 1'b1;
      tlb_fault = (n_tacc == fline);
      tlb_padr  = tlb_vadr + off;
    end
    if (dc_req && dc_age == dc_lat) dc_ack = 1'b1;
    if (force_dc) dc_ack = 1'b1;

    if (tlb_req && n_tacc < 2) check("tlb_vadr", tlb_vadr, e_vadr[n_tacc]);
    if (dc_req && n_dacc < 2) begin
      check("dc_padr", dc_padr, e_padr[n_dacc]);
      check("dc_sel", dc_sel, e_sel[n_dacc]);
      check("dc_we", 64'(dc_we), 64'(e_st));
    end
    if (fault) check("busy_at_fault", 64'(busy), 64'd0);

    if (tlb_req) begin
      if (tlb_ack) begin n_tacc++; tlb_age = 0; end else tlb_age++;
    end
    if (dc_req) begin
      n_dreq++;
      if (dc_ack) begin n_dacc++; dc_age = 0; end else dc_age++;
    end
    if (done) begin n_done++; done_at = cyc_i; end
    if (fault) n_fault++;
    if (agen_clr) n_clr++;
    if (agen_next) n_next++;
    if (agen_clr && (done || fault)) n_pair++;

    p_clr  = agen_clr;
    p_next = agen_next;
    @(posedge clk);
    #1;
    if (p_clr) agen_v = 1'b0;
    if (p_next) agen_adr = {agen_adr[63:6] + 58'd1, 6'd0};
    cyc_i++;
  endtask

  // Build the byte-level expectation and present the generator result.
  task automatic setup(input logic [63:0] adr, input logic [2:0] sz, input logic st,
                       input int tl, input int dl, input int fl, input logic [63:0] o);
    logic [127:0] bytes;
    bytes = '0;
    if (sz <= 3'd4)
      for (int i = 0; i < (1 << sz); i++) bytes[int'(adr[5:0]) + i] = 1'b1;
    e_lines   = (bytes[127:64] != '0) ? 2 : 1;
    e_vadr[0] = adr;
    e_vadr[1] = {adr[63:6] + 58'd1, 6'd0};
    for (int k = 0; k < 2; k++) e_padr[k] = (e_vadr[k] + o) & ~64'h3F;
    e_sel[0] = bytes[63:0];
    e_sel[1] = bytes[127:64];
    e_st  = st;
    e_bad = sz > 3'd4;
    off = o; tlb_lat = tl; dc_lat = dl; fline = fl;
    tlb_age = 0; dc_age = 0; n_tacc = 0; n_dacc = 0; n_dreq = 0;
    n_done = 0; n_fault = 0; n_clr = 0; n_next = 0; n_pair = 0;
    done_at = -1; cyc_i = 0;
    agen_v = 1'b1; agen_adr = adr; acc_sz = sz; is_store = st;
  endtask

  task automatic run_seq(input string tag, input logic [63:0] adr, input logic [2:0] sz,
                         input logic st, input int tl, input int dl, input int fl,
                         input logic [63:0] o);
    int x_done, x_fault, x_dacc, x_next;
    setup(adr, sz, st, tl, dl, fl, o);
    for (int k = 0; k < 100 && n_done == 0 && n_fault == 0; k++) cyc();
    cyc();
    if (e_bad) begin
      x_done = 0; x_fault = 1; x_dacc = 0; x_next = 0;
    end else if (fl >= 0 && fl < e_lines) begin
      x_done = 0; x_fault = 1; x_dacc = fl; x_next = 2 * fl;
    end else begin
      x_done = 1; x_fault = 0; x_dacc = e_lines; x_next = 2 * (e_lines - 1);
    end
    check({tag, "/done"}, 64'(n_done), 64'(x_done));
    check({tag, "/fault"}, 64'(n_fault), 64'(x_fault));
    check({tag, "/dc_accepts"}, 64'(n_dacc), 64'(x_dacc));
    check({tag, "/next_cycles"}, 64'(n_next), 64'(x_next));
    check({tag, "/clr"}, 64'(n_clr), 64'd1);
    check({tag, "/clr_with_end"}, 64'(n_pair), 64'd1);
    check({tag, "/busy_end"}, 64'(busy), 64'd0);
    if (x_done == 1)
      check({tag, "/latency"}, 64'(done_at),
            64'(1 + e_lines * (tl + dl + 2) + 2 * (e_lines - 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; agen_v = 1'b0; agen_adr = '0; acc_sz = '0; is_store = 1'b0;
    flush = 1'b0; tlb_ack = 1'b0; tlb_padr = '0; tlb_fault = 1'b0; dc_ack = 1'b0;
    force_dc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/ctl", 64'({agen_next, agen_clr, tlb_req, dc_req, dc_we, done, fault, busy}), 64'd0);
    check("rst/tlb_vadr", tlb_vadr, 64'd0);
    check("rst/dc_padr", dc_padr, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Non-crossing 8-byte access, immediate acks, padr 0x8000.
    run_seq("basic", 64'h1000, 3'd3, 1'b0, 0, 0, -1, 64'h7000);
    // 8 bytes at 0x103C spill 4 bytes into line 0x1040.
    run_seq("cross", 64'h103C, 3'd3, 1'b1, 0, 0, -1, 64'h7000);
    // Translation fault on line 1.
    run_seq("tlbfault1", 64'h2000, 3'd2, 1'b0, 1, 0, 0, 64'h0);
    // Translation fault on line 2 after line 1 was issued.
    run_seq("tlbfault2", 64'h30FE, 3'd2, 1'b1, 0, 0, 1, 64'h100);
    // Data-cache ack withheld 5 cycles; request must hold steady.
    run_seq("hold", 64'h2010, 3'd2, 1'b1, 0, 5, -1, 64'h4000);
    check("hold/req_cycles", 64'(n_dreq), 64'd6);
    // Illegal sizes.
    run_seq("illegal5", 64'h4000, 3'd5, 1'b0, 0, 0, -1, 64'h0);
    run_seq("illegal7", 64'h4000, 3'd7, 1'b0, 0, 0, -1, 64'h0);
    // 16 bytes at the very top of the address space: line 2 wraps to 0.
    run_seq("wrap", 64'hFFFF_FFFF_FFFF_FFF8, 3'd4, 1'b0, 0, 0, -1, 64'h0);

    // Flush in REQ2 together with dc_ack.
    setup(64'h103C, 3'd3, 1'b0, 0, 0, -1, 64'h7000);
    for (int k = 0; k < 40 && n_tacc < 2; k++) cyc();
    flush = 1'b1; force_dc = 1'b1;
    #1;
    check("flush/dc_req", 64'(dc_req), 64'd0);
    check("flush/busy", 64'(busy), 64'd1);
    cyc();
    flush = 1'b0; force_dc = 1'b0;
    check("flush/idle", 64'(busy), 64'd0);
    check("flush/clr", 64'(agen_clr), 64'd1);
    check("flush/no_done", 64'(done), 64'd0);
    cyc(); cyc();
    check("flush/n_done", 64'(n_done), 64'd0);
    check("flush/n_fault", 64'(n_fault), 64'd0);
    check("flush/dc_accepts", 64'(n_dacc), 64'd1);
    check("flush/n_clr", 64'(n_clr), 64'd1);

    // Reset in the middle of NXWAIT.
    setup(64'hFFFF_FFFF_FFFF_FFF8, 3'd4, 1'b1, 0, 0, -1, 64'h0);
    for (int k = 0; k < 40 && n_next == 0; k++) cyc();
    check("rstmid/in_nxwait", 64'(agen_next), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid/ctl", 64'({agen_next, agen_clr, tlb_req, dc_req, dc_we, done, fault, busy}), 64'd0);
    check("rstmid/tlb_vadr", tlb_vadr, 64'd0);
    check("rstmid/dc_padr", dc_padr, 64'd0);
    check("rstmid/dc_sel", dc_sel, 64'd0);
    rst = 1'b0; agen_v = 1'b0;
    cyc();
    check("rstmid/idle", 64'(busy), 64'd0);

    // Randomized accesses, latencies, translations and occasional faults.
    for (int n = 0; n < 40; n++) begin
      logic [63:0] a, o;
      int fl;
      a  = {$urandom, $urandom};
      a[5:0] = 6'($urandom_range(0, 63));
      o  = {$urandom, $urandom};
      fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1;
      run_seq("rand", a, 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), fl, o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
